// File: rtl/axi_read_master.sv
// AXI4 read-burst master: takes one {addr, len} command, issues a single INCR
// burst on AR, and forwards the R beats through a registered valid/ready stage.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ADDR  | presenting the burst on AR until arready
// DATA  | accepting R beats into the output register
// DONE  | one-cycle completion pulse carrying the error flag
module axi_read_master #(
   parameter int DATA_WIDTH    = 32,
   parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
   parameter int ADDRESS_WIDTH = 8,
   parameter int SIZE_LOG2     = $clog2(STROBE_WIDTH)
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
   input  logic [7:0]               cmd_len,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   output logic [ADDRESS_WIDTH-1:0] araddr,
   output logic [7:0]               arlen,
   output logic [2:0]               arsize,
   output logic [1:0]               arburst,
   output logic                     arvalid,
   input  logic                     arready,
   input  logic [DATA_WIDTH-1:0]    rdata,
   input  logic [1:0]               rresp,
   input  logic                     rlast,
   input  logic                     rvalid,
   output logic                     rready,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     done,
   output logic                     done_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK =
      ~ADDRESS_WIDTH'((1 << SIZE_LOG2) - 1);

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]               len_q, len_d;
   logic [8:0]               cnt_q, cnt_d;
   logic                     err_q, err_d;
   logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
   logic                     out_last_q, out_last_d;
   logic                     out_valid_q, out_valid_d;

   logic                     r_hs;
   logic [8:0]               cnt_inc;
   logic [8:0]               len_plus1;

   assign araddr    = addr_q;
   assign arlen     = len_q;
   assign arsize    = 3'(SIZE_LOG2);
   assign arburst   = 2'b01;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_valid = out_valid_q;

   // Counter saturates so an overlong burst without rlast cannot wrap back
   // onto a matching length.
   assign cnt_inc   = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;
   assign len_plus1 = {1'b0, len_q} + 9'd1;
   assign r_hs      = rvalid && rready;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      cmd_ready = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      done      = 1'b0;
      done_err  = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = !areset;
            if (cmd_valid && cmd_ready) begin
               addr_d  = cmd_addr & ADDR_MASK;
               len_d   = cmd_len;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = ADDR;
            end
         end
         ADDR: begin
            arvalid = 1'b1;
            if (arready) state_d = DATA;
         end
         DATA: begin
            // Accept only when the output register is empty or draining now.
            rready = !out_valid_q || out_ready;
            if (rvalid && rready) begin
               cnt_d = cnt_inc;
               if (rresp != 2'b00) err_d = 1'b1;
               if (rlast) begin
                  if (cnt_inc != len_plus1) err_d = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            done     = 1'b1;
            done_err = err_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      if (r_hs) begin
         out_data_d  = rdata;
         out_last_d  = rlast;
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

endmodule
